path_dram_sequencer: RTL and testbench

Issues the DRAM command stream for one Path ORAM path access: given a leaf and a direction (read or writeback), it walks the ORAML+1 buckets on that path and emits one DRAM command per burst. Write commands are throttled so each one is issued only after its data beat has already been accepted. The block tracks read-data and write-data beats and pulses completion when the whole path has moved. It sits between the backend's path control and the DRAM command port, beside the DRAM read path buffer and the encryption stage.

---
 rtl/path_dram_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_path_dram_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/path_dram_sequencer.sv
// path_dram_sequencer: walks one Path ORAM path (ORAML+1 buckets, BktBursts
// bursts each) and issues one DRAM command per burst. Writeback commands are
// throttled behind accepted write-data beats. Read and write beats are counted
// to decide completion, and protocol violations raise a sticky error flag.
//
// Build option: define PATHSEQ_LEAF_FIRST_WB_EN to walk writebacks leaf to root.
// Left undefined, writebacks use the same root-to-leaf order as reads.
//
// Handshakes: a path request transfers on a cycle where PathValid && PathReady.
// A command transfers on a cycle where DRAMCommandValid && DRAMCommandReady.
// Once DRAMCommandValid rises, it and DRAMAddress/DRAMCommand hold until that
// transfer. A write beat counts on a cycle where DRAMWriteDataValid &&
// DRAMWriteDataReady. Every cycle with DRAMReadDataValid high is one read beat.
module path_dram_sequencer #(
  parameter int ORAML       = 3,
  parameter int BktBursts   = 2,
  parameter int BurstStride = 8,
  parameter int DDRAWidth   = 28,
  parameter int DDRCWidth   = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 DRAMInitComplete,
  input  logic                 PathWrite,
  input  logic [ORAML-1:0]     Leaf,
  input  logic                 PathValid,
  output logic                 PathReady,
  output logic                 PathDone,
  output logic [DDRAWidth-1:0] DRAMAddress,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  input  logic                 DRAMReadDataValid,
  input  logic                 DRAMWriteDataValid,
  input  logic                 DRAMWriteDataReady,
  output logic                 ProtocolError,
  output logic [1:0]           DebugState
);

  localparam int N    = (ORAML + 1) * BktBursts;
  localparam int CW   = $clog2(N + 1);
  localparam int BS   = BktBursts * BurstStride;
  localparam int NatW = ORAML + 2 + $clog2(BS + 1);
  // Internal address is wide enough that the leaf-to-root halving step never
  // loses bits. The port only sees the low DDRAWidth bits.
  localparam int AW   = (NatW > DDRAWidth) ? NatW : DDRAWidth;
  localparam int BBW  = (BktBursts > 1) ? $clog2(BktBursts) : 1;

  localparam logic [CW-1:0]  NCnt      = CW'(N);
  localparam logic [CW-1:0]  NCntM1    = CW'(N - 1);
  localparam logic [AW-1:0]  BsA       = AW'(BS);
  localparam logic [AW-1:0]  StrideA   = AW'(BurstStride);
  localparam logic [BBW-1:0] LastBurst = BBW'(BktBursts - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state, stateNext;
  logic             wrReg, initQ, errReg, leafFirst, dirBit;
  logic [ORAML-1:0] leafSh;
  logic [AW-1:0]    levelBase, addrReg, stepBs, nextBase;
  logic [BBW-1:0]   burstIdx;
  logic [CW-1:0]    cmdCnt, rdCnt, wrCnt;
  logic             accept, cmdValid, cmdFire, wrBeat, rdBeat, errSet;

`ifdef PATHSEQ_LEAF_FIRST_WB_EN
  localparam logic [ORAML:0] LeafLvlOff = (ORAML + 1)'((1 << ORAML) - 1);

  // Base address of a bucket, built as a shift-add over the index bits.
  // This is evaluated only at path acceptance.
  function automatic logic [AW-1:0] bucketBase(input logic [ORAML:0] bucket);
    logic [AW-1:0] acc;
    acc = '0;
    for (int k = 0; k <= ORAML; k++) begin
      if (bucket[k]) acc = acc + (BsA << k);
    end
    return acc;
  endfunction

  assign leafFirst = wrReg;
`else
  assign leafFirst = 1'b0;
`endif

  assign accept    = (state == IDLE) && PathValid && PathReady;
  assign PathReady = (state == IDLE) && initQ;
  // In writeback, a command may issue only while registered beats lead commands.
  assign cmdValid  = (state == ISSUE) && (!wrReg || (wrCnt > cmdCnt));
  assign cmdFire   = cmdValid && DRAMCommandReady;
  assign wrBeat    = DRAMWriteDataValid && DRAMWriteDataReady;
  assign rdBeat    = DRAMReadDataValid;

  assign DRAMCommandValid = cmdValid;
  assign DRAMAddress      = addrReg[DDRAWidth-1:0];
  assign DRAMCommand      = wrReg ? DDRCWidth'(0) : DDRCWidth'(1);
  assign ProtocolError    = errReg;
  assign DebugState       = state;

  // Next bucket base without a multiplier. Let b be the current bucket.
  //   Towards the leaf: child = 2b + 1 + bit, so base' = 2*base + BS*(1+bit).
  //   Towards the root: parent = (b - 1 - bit)/2, so base' = (base - BS*(1+bit))/2.
  assign dirBit   = leafFirst ? leafSh[0] : leafSh[ORAML-1];
  assign stepBs   = dirBit ? (BsA << 1) : BsA;
  assign nextBase = leafFirst ? ((levelBase - stepBs) >> 1) : ((levelBase << 1) + stepBs);

  // Write throttle never blocks a read path.
  // Beats already counted on earlier cycles are what open the throttle.
  assign errSet = (rdBeat && (state == IDLE)) ||
                  (rdBeat && (state != IDLE) && (rdCnt == NCnt)) ||
                  (wrBeat && ((state == IDLE) ? !(accept && PathWrite) : (wrCnt == NCnt)));

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic and the completion pulse.
  always_comb begin
    stateNext = state;
    PathDone  = 1'b0;
    case (state)
      IDLE:  if (accept) stateNext = ISSUE;
      ISSUE: if (cmdFire && (cmdCnt == NCntM1)) stateNext = DRAIN;
      DRAIN: if (wrReg ? (wrCnt == NCnt) : (rdCnt == NCnt)) stateNext = DONE;
      DONE: begin
        PathDone  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Path walk: latch the request, then step burst and bucket addresses on each accepted command.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrReg     <= 1'b0;
      leafSh    <= '0;
      levelBase <= '0;
      addrReg   <= '0;
      burstIdx  <= '0;
      cmdCnt    <= '0;
    end else if (accept) begin
      wrReg    <= PathWrite;
      leafSh   <= Leaf;
      burstIdx <= '0;
      cmdCnt   <= '0;
`ifdef PATHSEQ_LEAF_FIRST_WB_EN
      if (PathWrite) begin
        levelBase <= bucketBase({1'b0, Leaf} + LeafLvlOff);
        addrReg   <= bucketBase({1'b0, Leaf} + LeafLvlOff);
      end else begin
        levelBase <= '0;
        addrReg   <= '0;
      end
`else
      levelBase <= '0;
      addrReg   <= '0;
`endif
    end else if (cmdFire) begin
      cmdCnt <= cmdCnt + 1'b1;
      if (burstIdx == LastBurst) begin
        burstIdx  <= '0;
        levelBase <= nextBase;
        addrReg   <= nextBase;
        leafSh    <= leafFirst ? (leafSh >> 1) : (leafSh << 1);
      end else begin
        burstIdx <= burstIdx + 1'b1;
        addrReg  <= addrReg + StrideA;
      end
    end
  end

  // Beat counters (saturating at N), init synchroniser and sticky error flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rdCnt  <= '0;
      wrCnt  <= '0;
      initQ  <= 1'b0;
      errReg <= 1'b0;
    end else begin
      initQ <= DRAMInitComplete;
      if (errSet) errReg <= 1'b1;

      if (accept)                                      rdCnt <= '0;
      else if (rdBeat && (state != IDLE) && (rdCnt != NCnt)) rdCnt <= rdCnt + 1'b1;

      // A writeback beat on the accepting cycle is kept as the first count.
      if (accept)                                       wrCnt <= (PathWrite && wrBeat) ? CW'(1) : '0;
      else if (wrBeat && (state != IDLE) && (wrCnt != NCnt)) wrCnt <= wrCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_path_dram_sequencer.sv
// Bench for path_dram_sequencer: directed path accesses checked against a
// path-level model (bucket formula, beat/command bookkeeping) plus literal
// address tables for leaf 5.
`timescale 1ns/1ps
module tb_path_dram_sequencer;

  localparam int ORAML  = 3;
  localparam int BKT    = 2;
  localparam int STRIDE = 8;
  localparam int AW     = 28;
  localparam int N      = (ORAML + 1) * BKT;
`ifdef PATHSEQ_LEAF_FIRST_WB_EN
  localparam bit LEAF_FIRST = 1'b1;
`else
  localparam bit LEAF_FIRST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             DRAMInitComplete, PathWrite, PathValid, PathReady, PathDone;
  logic [ORAML-1:0] Leaf;
  logic [AW-1:0]    DRAMAddress;
  logic [2:0]       DRAMCommand;
  logic             DRAMCommandValid, DRAMCommandReady, DRAMReadDataValid;
  logic             DRAMWriteDataValid, DRAMWriteDataReady, ProtocolError;
  logic [1:0]       DebugState;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 400000", $time);
    $fatal(1);
  end

  path_dram_sequencer #(
    .ORAML(ORAML), .BktBursts(BKT), .BurstStride(STRIDE), .DDRAWidth(AW), .DDRCWidth(3)
  ) dut (
    .Clock(clk), .Reset(rst_n), .DRAMInitComplete(DRAMInitComplete),
    .PathWrite(PathWrite), .Leaf(Leaf), .PathValid(PathValid), .PathReady(PathReady),
    .PathDone(PathDone), .DRAMAddress(DRAMAddress), .DRAMCommand(DRAMCommand),
    .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady),
    .DRAMReadDataValid(DRAMReadDataValid), .DRAMWriteDataValid(DRAMWriteDataValid),
    .DRAMWriteDataReady(DRAMWriteDataReady), .ProtocolError(ProtocolError),
    .DebugState(DebugState)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs_addr[N];
  int            obs_cyc[N];
  bit            path_active = 0, m_wr = 0, done_seen = 0, prev_stall = 0;
  int            m_cmds = 0, m_rd = 0, m_wr_beats = 0;
  int            last_cmd_cyc = 0, last_beat_cyc = 0, accept_cyc = 0;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_cmd;

  logic [AW-1:0] read_tbl [N] = '{0, 8, 32, 40, 80, 88, 192, 200};
`ifdef PATHSEQ_LEAF_FIRST_WB_EN
  logic [AW-1:0] wb_tbl   [N] = '{192, 200, 80, 88, 32, 40, 0, 8};
`else
  logic [AW-1:0] wb_tbl   [N] = '{0, 8, 32, 40, 80, 88, 192, 200};
`endif

  // Expected burst addresses straight from the bucket formula.
  function automatic void build_path(input bit wr, input int leaf);
    int lvl, bucket;
    exp_q.delete();
    for (int j = 0; j <= ORAML; j++) begin
      lvl    = (wr && LEAF_FIRST) ? (ORAML - j) : j;
      bucket = ((1 << lvl) - 1) + (leaf >> (ORAML - lvl));
      for (int b = 0; b < BKT; b++) exp_q.push_back(AW'((bucket * BKT + b) * STRIDE));
    end
  endfunction

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    bit            exp_done;
    int            last;
    if (!rst_n) begin
      path_active = 0;
      prev_stall  = 0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        check("hold_valid", DRAMCommandValid, 1);
        check("hold_addr", DRAMAddress, prev_addr);
        check("hold_cmd", DRAMCommand, prev_cmd);
      end
      prev_stall = DRAMCommandValid && !DRAMCommandReady;
      prev_addr  = DRAMAddress;
      prev_cmd   = DRAMCommand;

      if (!path_active) begin
        check("idle_no_cmd", DRAMCommandValid, 0);
      end else begin
        if (cyc == accept_cyc + 1 && !m_wr) check("first_cmd_latency", DRAMCommandValid, 1);
        if (DRAMCommandValid && DRAMCommandReady) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_cmd: got address %0d required no command", DRAMAddress);
          end else begin
            e = exp_q.pop_front();
            check("cmd_addr", DRAMAddress, e);
            check("cmd_type", DRAMCommand, m_wr ? 3'b000 : 3'b001);
            if (m_wr) check("write_throttle", (m_cmds < m_wr_beats), 1);
            if (m_cmds < N) begin
              obs_addr[m_cmds] = DRAMAddress;
              obs_cyc[m_cmds]  = cyc;
            end
            m_cmds++;
            if (m_cmds == N) last_cmd_cyc = cyc;
          end
        end
        if (DRAMReadDataValid) begin
          m_rd++;
          if (!m_wr && m_rd == N) last_beat_cyc = cyc;
        end
        if (DRAMWriteDataValid && DRAMWriteDataReady) begin
          m_wr_beats++;
          if (m_wr && m_wr_beats == N) last_beat_cyc = cyc;
        end
      end

      // Completion lands two cycles after the later of last command / last needed beat.
      last     = (last_cmd_cyc > last_beat_cyc) ? last_cmd_cyc : last_beat_cyc;
      exp_done = path_active && (m_cmds >= N) && (m_wr ? (m_wr_beats >= N) : (m_rd >= N)) &&
                 (cyc == last + 2);
      check("path_done", PathDone, exp_done);
      if (exp_done) begin
        path_active = 0;
        done_seen   = 1;
      end

      if (PathValid && PathReady) begin
        build_path(PathWrite, int'(Leaf));
        path_active  = 1;
        m_wr         = PathWrite;
        m_cmds       = 0;
        m_rd         = 0;
        m_wr_beats   = 0;
        last_cmd_cyc = 0;
        last_beat_cyc = 0;
        accept_cyc   = cyc;
        done_seen    = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    PathValid          = 0;
    DRAMCommandReady   = 0;
    DRAMReadDataValid  = 0;
    DRAMWriteDataValid = 0;
    DRAMWriteDataReady = 1;
  endtask

  // One path access. wr_period: a write beat every wr_period cycles.
  // extra_beat: send a 9th read beat. stop_after > 0: leave after that many commands.
  task automatic run_path(input bit wr, input int leaf, input bit rnd_ready,
                          input int wr_period, input bit extra_beat, input int stop_after);
    int rd_sent, wr_sent;
    bit extra_sent, ok;
    PathWrite = wr;
    Leaf      = ORAML'(leaf);
    PathValid = 1;
    ok        = 0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (PathReady) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    PathValid = 0;
    if (!ok) begin
      check("accept_timeout", PathReady, 1);
      return;
    end
    rd_sent    = 0;
    wr_sent    = 0;
    extra_sent = 0;
    for (int k = 0; k < 400; k++) begin
      if (done_seen) break;
      if (stop_after > 0 && m_cmds >= stop_after) break;
      DRAMCommandReady   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      DRAMReadDataValid  = 0;
      if (!wr && rd_sent < m_cmds) begin
        DRAMReadDataValid = 1;
        rd_sent++;
      end else if (!wr && extra_beat && !extra_sent && rd_sent == N) begin
        DRAMReadDataValid = 1;
        extra_sent = 1;
      end
      DRAMWriteDataReady = 1;
      DRAMWriteDataValid = wr && (wr_sent < N) && (k % wr_period == 0);
      if (DRAMWriteDataValid) wr_sent++;
      @(posedge clk); #1;
    end
    idle_inputs();
    if (stop_after == 0) begin
      check("path_done_seen", done_seen, 1);
      check("ready_after_done", PathReady, 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n            = 0;
    DRAMInitComplete = 1;
    PathWrite        = 0;
    Leaf             = '0;
    idle_inputs();
    #12;
    check("rst_ready", PathReady, 0);
    check("rst_done", PathDone, 0);
    check("rst_valid", DRAMCommandValid, 0);
    check("rst_addr", DRAMAddress, 0);
    check("rst_cmd", DRAMCommand, 3'b001);
    check("rst_err", ProtocolError, 0);
    check("rst_state", DebugState, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Read, leaf 5, ready held high: literal addresses on consecutive cycles.
    run_path(0, 5, 0, 1, 0, 0);
    for (int i = 0; i < N; i++) begin
      check("rd5_addr", obs_addr[i], read_tbl[i]);
      check("rd5_cycle", obs_cyc[i], accept_cyc + 1 + i);
    end
    check("rd5_no_err", ProtocolError, 0);

    // Writeback, leaf 5, one beat per cycle: order depends on the build option.
    run_path(1, 5, 0, 1, 0, 0);
    for (int i = 0; i < N; i++) check("wb5_addr", obs_addr[i], wb_tbl[i]);

    // Write throttle: beats every third cycle.
    run_path(1, 2, 0, 3, 0, 0);

    // Backpressure on both directions.
    run_path(0, 6, 1, 1, 0, 0);
    run_path(1, 3, 1, 2, 0, 0);
    check("bp_no_err", ProtocolError, 0);

    // Ninth read beat trips the sticky error.
    run_path(0, 7, 0, 1, 1, 0);
    check("err_9th_beat", ProtocolError, 1);

    // Reset mid-path after three commands: outputs clear without a clock edge.
    run_path(0, 1, 0, 1, 0, 3);
    #2 rst_n = 0;
    #1;
    check("midrst_ready", PathReady, 0);
    check("midrst_done", PathDone, 0);
    check("midrst_valid", DRAMCommandValid, 0);
    check("midrst_addr", DRAMAddress, 0);
    check("midrst_cmd", DRAMCommand, 3'b001);
    check("midrst_err", ProtocolError, 0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    @(posedge clk); #1 DRAMReadDataValid = 1;
    @(posedge clk); #1 DRAMReadDataValid = 0;
    check("late_beat_err", ProtocolError, 1);

    // Init low gates acceptance.
    rst_n            = 0;
    DRAMInitComplete = 0;
    @(negedge clk); rst_n = 1;
    check("err_cleared", ProtocolError, 0);
    @(posedge clk); #1;
    PathWrite = 0;
    Leaf      = '0;
    PathValid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("init_gate_ready", PathReady, 0);
    end
    @(posedge clk); #1;
    PathValid        = 0;
    DRAMInitComplete = 1;
    run_path(0, 0, 0, 1, 0, 0);
    check("final_no_err", ProtocolError, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
